// File: rtl/m72_pal_pkg.sv
// Shared palette-DMA definitions: plane codes, FSM states
// and the palette address builder.
package m72_pal_pkg;

  localparam logic [1:0] PLANE_R = 2'd0;
  localparam logic [1:0] PLANE_G = 2'd1;
  localparam logic [1:0] PLANE_B = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    FETCH,
    HOLD,
    WRITE,
    FINISH
  } pal_state_e;

  // A[11:10]=plane, A[8:1]=index, all else 0
  function automatic logic [19:0] pal_addr(
    input logic [1:0] plane,
    input logic [7:0] idx
  );
    pal_addr = {8'd0, plane, 1'b0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/pal_bus_mux.sv
// Palette bus mux: CPU owns the bus whenever it strobes,
// otherwise the DMA write slot drives it.
//   dma_slot/dma_a/dma_din : DMA request and data
//   cpu_*                  : CPU side of the palette bus
//   pal_*                  : to palette chip
//   cpu_busy, dma_wr       : bus ownership this cycle
module pal_bus_mux (
  input  logic        dma_slot,
  input  logic [19:0] dma_a,
  input  logic [15:0] dma_din,
  input  logic [19:0] cpu_a,
  input  logic        cpu_g,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [15:0] cpu_din,
  output logic [19:0] pal_a,
  output logic        pal_g,
  output logic        pal_mwr,
  output logic        pal_mrd,
  output logic [15:0] pal_din,
  output logic        cpu_busy,
  output logic        dma_wr
);

  assign cpu_busy = cpu_g & (cpu_wr | cpu_rd);
  assign dma_wr   = dma_slot & ~cpu_busy;

  always_comb begin
    pal_a   = cpu_a;
    pal_g   = cpu_g;
    pal_mwr = cpu_wr;
    pal_mrd = cpu_rd;
    pal_din = cpu_din;
    if (dma_wr) begin
      pal_a   = dma_a;
      pal_g   = 1'b1;
      pal_mwr = 1'b1;
      pal_mrd = 1'b0;
      pal_din = dma_din;
    end
  end

endmodule

// File: rtl/pal_dma_ctrl.sv
// Vblank palette uploader: copies R/G/B planes from memory
// into the palette chip, sharing its bus with the CPU.
//   CLK_32M/RESET_N : clock, async active-low reset
//   VBLANK/START/ABORT/SRC_BASE : control
//   MEM_*  : memory read port
//   CPU_*  : CPU palette bus in, PAL_* : palette chip out
//   BUSY/DONE : status
module pal_dma_ctrl
  import m72_pal_pkg::*;
#(
  parameter int ENTRIES         = 256,
  parameter int PLANES          = 3,
  parameter bit PAUSE_ON_ACTIVE = 1'b1
) (
  input  logic        CLK_32M,
  input  logic        RESET_N,
  input  logic        VBLANK,
  input  logic        START,
  input  logic        ABORT,
  input  logic [19:0] SRC_BASE,
  output logic        MEM_REQ,
  output logic [19:0] MEM_ADDR,
  input  logic        MEM_ACK,
  input  logic [15:0] MEM_DATA,
  input  logic [19:0] CPU_A,
  input  logic        CPU_G,
  input  logic        CPU_WR,
  input  logic        CPU_RD,
  input  logic [15:0] CPU_DIN,
  output logic [19:0] PAL_A,
  output logic        PAL_G,
  output logic        PAL_MWR,
  output logic        PAL_MRD,
  output logic [15:0] PAL_DIN,
  output logic        BUSY,
  output logic        DONE
);

  pal_state_e  state;
  logic [19:0] src_q;
  logic [9:0]  k;
  logic [1:0]  plane;
  logic [7:0]  idx;
  logic [4:0]  wr_buf;

  logic        dma_slot;
  logic        dma_wr;
  logic        cpu_busy;
  logic [9:0]  k_nxt;
  logic        last_word;
  logic        idx_wrap;
  logic [19:0] cur_addr;
  logic [19:0] nxt_addr;
  logic [19:0] dma_a;
  logic        unused_mem_hi;

  assign unused_mem_hi = ^MEM_DATA[15:5];

  assign k_nxt     = k + 10'd1;
  assign last_word = (k == 10'(PLANES * ENTRIES - 1));
  assign idx_wrap  = (idx == 8'(ENTRIES - 1));
  assign cur_addr  = src_q + {9'd0, k, 1'b0};
  assign nxt_addr  = src_q + {9'd0, k_nxt, 1'b0};
  assign dma_a     = pal_addr(plane, idx);
  assign dma_slot  = (state == WRITE);

  pal_bus_mux u_mux (
    .dma_slot (dma_slot),
    .dma_a    (dma_a),
    .dma_din  ({11'd0, wr_buf}),
    .cpu_a    (CPU_A),
    .cpu_g    (CPU_G),
    .cpu_wr   (CPU_WR),
    .cpu_rd   (CPU_RD),
    .cpu_din  (CPU_DIN),
    .pal_a    (PAL_A),
    .pal_g    (PAL_G),
    .pal_mwr  (PAL_MWR),
    .pal_mrd  (PAL_MRD),
    .pal_din  (PAL_DIN),
    .cpu_busy (cpu_busy),
    .dma_wr   (dma_wr)
  );

  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      src_q    <= '0;
      k        <= '0;
      plane    <= PLANE_R;
      idx      <= '0;
      wr_buf   <= '0;
      MEM_REQ  <= 1'b0;
      MEM_ADDR <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else if (ABORT) begin
      state   <= IDLE;
      MEM_REQ <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            src_q <= SRC_BASE;
            k     <= '0;
            plane <= PLANE_R;
            idx   <= '0;
            BUSY  <= 1'b1;
            state <= ARMED;
          end
        end
        ARMED: begin
          if (VBLANK) begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= cur_addr;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (MEM_ACK) begin
            wr_buf  <= MEM_DATA[4:0];
            MEM_REQ <= 1'b0;
            state   <= WRITE;
          end
        end
        HOLD: begin
          if (VBLANK) begin
            MEM_REQ  <= 1'b1;
            MEM_ADDR <= cur_addr;
            state    <= FETCH;
          end
        end
        WRITE: begin
          // a CPU cycle steals the slot; retry next cycle
          if (dma_wr) begin
            k <= k_nxt;
            if (idx_wrap) begin
              idx   <= '0;
              plane <= plane + 2'd1;
            end else begin
              idx <= idx + 8'd1;
            end
            if (last_word) begin
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= FINISH;
            end else if (PAUSE_ON_ACTIVE && !VBLANK) begin
              state <= HOLD;
            end else begin
              MEM_REQ  <= 1'b1;
              MEM_ADDR <= nxt_addr;
              state    <= FETCH;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pal_dma_ctrl.sv
// Directed testbench for pal_dma_ctrl with memory responder
// and palette write monitor.
module tb_pal_dma_ctrl;

  localparam logic [19:0] BASE = 20'h10000;

  logic        CLK_32M = 1'b0;
  logic        RESET_N;
  logic        VBLANK;
  logic        START;
  logic        ABORT;
  logic [19:0] SRC_BASE;
  logic        MEM_REQ;
  logic [19:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_DATA;
  logic [19:0] CPU_A;
  logic        CPU_G;
  logic        CPU_WR;
  logic        CPU_RD;
  logic [15:0] CPU_DIN;
  logic [19:0] PAL_A;
  logic        PAL_G;
  logic        PAL_MWR;
  logic        PAL_MRD;
  logic [15:0] PAL_DIN;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int dma_wcount = 0;
  int cpu_wcount = 0;
  int tot_wr = 0;
  int done_cnt = 0;
  int order_err = 0;
  int addr_err = 0;
  int cpu_err = 0;
  int cpu_first_cyc = 0;
  int dma10_cyc = 0;
  logic [19:0] first_a;
  logic [19:0] last_a;
  logic [15:0] pal_mem [0:1023];
  bit mem_en = 1'b0;
  logic req_q;

  pal_dma_ctrl dut (
    .CLK_32M  (CLK_32M),
    .RESET_N  (RESET_N),
    .VBLANK   (VBLANK),
    .START    (START),
    .ABORT    (ABORT),
    .SRC_BASE (SRC_BASE),
    .MEM_REQ  (MEM_REQ),
    .MEM_ADDR (MEM_ADDR),
    .MEM_ACK  (MEM_ACK),
    .MEM_DATA (MEM_DATA),
    .CPU_A    (CPU_A),
    .CPU_G    (CPU_G),
    .CPU_WR   (CPU_WR),
    .CPU_RD   (CPU_RD),
    .CPU_DIN  (CPU_DIN),
    .PAL_A    (PAL_A),
    .PAL_G    (PAL_G),
    .PAL_MWR  (PAL_MWR),
    .PAL_MRD  (PAL_MRD),
    .PAL_DIN  (PAL_DIN),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #10 CLK_32M = ~CLK_32M;

  function automatic logic [19:0] exp_a(input int k);
    logic [19:0] a;
    a = 20'((k / 256) * 1024 + (k % 256) * 2);
    return a;
  endfunction

  // memory: ACK two cycles after REQ rises, word k = k & 1F
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge CLK_32M);
      #1;
      if (mem_en) begin
        if (MEM_ACK === 1'b1 || RESET_N !== 1'b1) begin
          MEM_ACK = 1'b0;
          cnt = 0;
        end else if (MEM_REQ === 1'b1) begin
          cnt++;
          if (cnt == 2) begin
            MEM_ACK  = 1'b1;
            MEM_DATA = {11'h5A5, MEM_ADDR[5:1]};
            cnt = 0;
          end
        end
      end
    end
  end

  // palette chip model and bus monitor
  initial begin
    req_q = 1'b0;
    forever begin
      @(negedge CLK_32M);
      cyc++;
      if (DONE === 1'b1) done_cnt++;
      if (MEM_REQ === 1'b1 && req_q !== 1'b1) begin
        if (MEM_ADDR !== 20'(BASE + 2 * dma_wcount))
          addr_err++;
      end
      req_q = MEM_REQ;
      if (PAL_G === 1'b1 && PAL_MWR === 1'b1) begin
        tot_wr++;
        if (CPU_G && CPU_WR) begin
          if (cpu_wcount == 0) cpu_first_cyc = cyc;
          cpu_wcount++;
          if (PAL_A !== CPU_A || PAL_DIN !== CPU_DIN)
            cpu_err++;
        end else begin
          if (PAL_A !== exp_a(dma_wcount) || PAL_MRD !== 1'b0)
            order_err++;
          if (dma_wcount == 0) first_a = PAL_A;
          if (dma_wcount == 10) dma10_cyc = cyc;
          last_a = PAL_A;
          dma_wcount++;
        end
        pal_mem[{PAL_A[11:10], PAL_A[8:1]}] = PAL_DIN;
      end
    end
  end

  task automatic clear_counts();
    dma_wcount = 0;
    cpu_wcount = 0;
    tot_wr = 0;
    done_cnt = 0;
    order_err = 0;
    addr_err = 0;
    cpu_err = 0;
    cpu_first_cyc = 0;
    dma10_cyc = 0;
    for (int i = 0; i < 1024; i++) pal_mem[i] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(posedge CLK_32M);
    #2 START = 1'b1;
    @(posedge CLK_32M);
    #2 START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK_32M);
      #2;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pal_bad_count(output int bad);
    bad = 0;
    for (int k = 0; k < 768; k++)
      if (k != 6 && pal_mem[k] !== 16'(k & 31)) bad++;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    CPU_A = 20'h00ABC;
    CPU_G = 1'b1;
    CPU_WR = 1'b0;
    CPU_RD = 1'b1;
    CPU_DIN = 16'h1234;
    #35;
    checks++;
    if (MEM_REQ !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: req=%b busy=%b done=%b want 0",
               MEM_REQ, BUSY, DONE);
    end
    checks++;
    if (MEM_ADDR !== 20'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h want 0", MEM_ADDR);
    end
    checks++;
    if (PAL_A !== 20'h00ABC || PAL_MRD !== 1'b1 ||
        PAL_MWR !== 1'b0 || PAL_DIN !== 16'h1234) begin
      failures++;
      $display("FAIL reset_mux: A=%h mrd=%b mwr=%b din=%h want ABC 1 0 1234",
               PAL_A, PAL_MRD, PAL_MWR, PAL_DIN);
    end
    CPU_G = 1'b0;
    CPU_RD = 1'b0;
    CPU_A = 20'h0;
    CPU_DIN = 16'h0;
    @(negedge CLK_32M);
    RESET_N = 1'b1;
    repeat (2) @(posedge CLK_32M);
  endtask

  task automatic test_full_copy();
    bit ok;
    int bad;
    clear_counts();
    VBLANK = 1'b1;
    mem_en = 1'b1;
    pulse_start();
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL full_busy: got %b want 1", BUSY);
    end
    wait_done(8000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_timeout: done=%0d want 1", done_cnt);
    end
    repeat (5) @(posedge CLK_32M);
    #2;
    checks++;
    if (dma_wcount !== 768) begin
      failures++;
      $display("FAIL full_count: got %0d want 768", dma_wcount);
    end
    checks++;
    if (first_a !== 20'h000 || last_a !== 20'h9FE) begin
      failures++;
      $display("FAIL full_ends: first=%h last=%h want 000 9FE",
               first_a, last_a);
    end
    checks++;
    if (done_cnt !== 1 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL full_done: pulses=%0d busy=%b want 1 0",
               done_cnt, BUSY);
    end
    checks++;
    if (order_err !== 0 || addr_err !== 0) begin
      failures++;
      $display("FAIL full_order: aerr=%0d ferr=%0d want 0 0",
               order_err, addr_err);
    end
    pal_bad_count(bad);
    checks++;
    if (bad !== 0 || pal_mem[6] !== 16'd6) begin
      failures++;
      $display("FAIL full_readback: bad=%0d p6=%h want 0 6",
               bad, pal_mem[6]);
    end
  endtask

  task automatic test_contention();
    bit ok;
    bit seen;
    clear_counts();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge CLK_32M);
      #2;
      if (dma_wcount == 10 && MEM_ACK === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL cont_reach: writes=%0d want 10", dma_wcount);
    end
    @(posedge CLK_32M);
    #2;
    CPU_G = 1'b1;
    CPU_WR = 1'b1;
    CPU_A = 20'h0000C;
    CPU_DIN = 16'hBEEF;
    repeat (3) @(posedge CLK_32M);
    #2;
    CPU_G = 1'b0;
    CPU_WR = 1'b0;
    wait_done(8000, ok);
    repeat (3) @(posedge CLK_32M);
    #2;
    checks++;
    if (!ok || dma_wcount !== 768) begin
      failures++;
      $display("FAIL cont_count: ok=%b writes=%0d want 1 768",
               ok, dma_wcount);
    end
    checks++;
    if (cpu_wcount !== 3 || cpu_err !== 0) begin
      failures++;
      $display("FAIL cont_cpu: writes=%0d err=%0d want 3 0",
               cpu_wcount, cpu_err);
    end
    checks++;
    if (dma10_cyc - cpu_first_cyc !== 3) begin
      failures++;
      $display("FAIL cont_delay: got %0d want 3",
               dma10_cyc - cpu_first_cyc);
    end
    checks++;
    if (pal_mem[6] !== 16'hBEEF || pal_mem[10] !== 16'd10) begin
      failures++;
      $display("FAIL cont_data: p6=%h p10=%h want BEEF 000a",
               pal_mem[6], pal_mem[10]);
    end
    checks++;
    if (order_err !== 0 || addr_err !== 0) begin
      failures++;
      $display("FAIL cont_order: aerr=%0d ferr=%0d want 0 0",
               order_err, addr_err);
    end
  endtask

  task automatic test_pause();
    bit ok;
    bit seen;
    int reqs;
    int bad;
    clear_counts();
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK_32M);
      #1;
      if (dma_wcount == 300) begin
        seen = 1'b1;
        break;
      end
    end
    VBLANK = 1'b0;
    reqs = 0;
    repeat (20) begin
      @(posedge CLK_32M);
      #2;
      if (MEM_REQ !== 1'b0) reqs++;
    end
    checks++;
    if (!seen || reqs !== 0 || dma_wcount !== 300) begin
      failures++;
      $display("FAIL pause_hold: seen=%b reqs=%0d writes=%0d want 1 0 300",
               seen, reqs, dma_wcount);
    end
    checks++;
    if (BUSY !== 1'b1) begin
      failures++;
      $display("FAIL pause_busy: got %b want 1", BUSY);
    end
    VBLANK = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK_32M);
      #2;
      if (MEM_REQ === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || MEM_ADDR !== 20'(BASE + 600)) begin
      failures++;
      $display("FAIL pause_resume: req=%b addr=%h want 1 %h",
               seen, MEM_ADDR, 20'(BASE + 600));
    end
    wait_done(8000, ok);
    pal_bad_count(bad);
    checks++;
    if (!ok || dma_wcount !== 768 || bad !== 0 || addr_err !== 0) begin
      failures++;
      $display("FAIL pause_finish: ok=%b writes=%0d bad=%0d ferr=%0d",
               ok, dma_wcount, bad, addr_err);
    end
  endtask

  task automatic test_arm_early();
    int bad;
    repeat (3) @(posedge CLK_32M);
    clear_counts();
    mem_en = 1'b0;
    MEM_ACK = 1'b0;
    VBLANK = 1'b0;
    pulse_start();
    bad = 0;
    repeat (10) begin
      @(posedge CLK_32M);
      #2;
      if (BUSY !== 1'b1 || MEM_REQ !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL arm_wait: bad cycles=%0d want 0", bad);
    end
    VBLANK = 1'b1;
    @(posedge CLK_32M);
    #2;
    checks++;
    if (MEM_REQ !== 1'b1 || MEM_ADDR !== BASE) begin
      failures++;
      $display("FAIL arm_go: req=%b addr=%h want 1 %h",
               MEM_REQ, MEM_ADDR, BASE);
    end
  endtask

  task automatic test_abort();
    int wr0;
    @(posedge CLK_32M);
    #2 ABORT = 1'b1;
    @(posedge CLK_32M);
    #2 ABORT = 1'b0;
    checks++;
    if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop: req=%b busy=%b want 0 0",
               MEM_REQ, BUSY);
    end
    wr0 = tot_wr;
    MEM_ACK = 1'b1;
    MEM_DATA = 16'h0015;
    @(posedge CLK_32M);
    #2 MEM_ACK = 1'b0;
    repeat (5) @(posedge CLK_32M);
    #2;
    checks++;
    if (tot_wr !== wr0 || done_cnt !== 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL abort_late_ack: writes=%0d done=%0d busy=%b want %0d 0 0",
               tot_wr, done_cnt, BUSY, wr0);
    end
    @(posedge CLK_32M);
    #2;
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK_32M);
    #2;
    START = 1'b0;
    ABORT = 1'b0;
    repeat (3) @(posedge CLK_32M);
    #2;
    checks++;
    if (BUSY !== 1'b0 || MEM_REQ !== 1'b0) begin
      failures++;
      $display("FAIL abort_start: busy=%b req=%b want 0 0",
               BUSY, MEM_REQ);
    end
  endtask

  task automatic test_reset_in_write();
    bit seen;
    int snap;
    clear_counts();
    mem_en = 1'b1;
    VBLANK = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK_32M);
      #2;
      if (PAL_MWR === 1'b1 && dma_wcount == 4) begin
        seen = 1'b1;
        break;
      end
    end
    snap = dma_wcount;
    #1 RESET_N = 1'b0;
    #1;
    checks++;
    if (!seen || MEM_REQ !== 1'b0 || BUSY !== 1'b0 ||
        DONE !== 1'b0 || MEM_ADDR !== 20'h0) begin
      failures++;
      $display("FAIL rstw_ctl: seen=%b req=%b busy=%b done=%b addr=%h",
               seen, MEM_REQ, BUSY, DONE, MEM_ADDR);
    end
    checks++;
    if (PAL_MWR !== 1'b0 || PAL_G !== 1'b0) begin
      failures++;
      $display("FAIL rstw_idle: mwr=%b g=%b want 0 0", PAL_MWR, PAL_G);
    end
    CPU_A = 20'h00123;
    CPU_G = 1'b1;
    CPU_WR = 1'b1;
    CPU_DIN = 16'h5A5A;
    #1;
    checks++;
    if (PAL_A !== 20'h00123 || PAL_DIN !== 16'h5A5A || PAL_MWR !== 1'b1) begin
      failures++;
      $display("FAIL rstw_mux: A=%h din=%h mwr=%b want 123 5a5a 1",
               PAL_A, PAL_DIN, PAL_MWR);
    end
    repeat (4) @(posedge CLK_32M);
    #2;
    CPU_G = 1'b0;
    CPU_WR = 1'b0;
    checks++;
    if (dma_wcount !== snap) begin
      failures++;
      $display("FAIL rstw_nowrite: writes=%0d want %0d", dma_wcount, snap);
    end
    RESET_N = 1'b1;
  endtask

  initial begin
    RESET_N = 1'b0;
    VBLANK = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    SRC_BASE = BASE;
    MEM_ACK = 1'b0;
    MEM_DATA = 16'h0;
    CPU_A = 20'h0;
    CPU_G = 1'b0;
    CPU_WR = 1'b0;
    CPU_RD = 1'b0;
    CPU_DIN = 16'h0;
    test_reset();
    test_full_copy();
    test_contention();
    test_pause();
    test_arm_early();
    test_abort();
    test_reset_in_write();
    repeat (3) @(posedge CLK_32M);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
